// File: rtl/vmask_gen_if.sv
// rtl/vmask_gen_if.sv - request/mask-word handshake bundle for vmask_gen
interface vmask_gen_if #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int CNT_WIDTH       = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CNT_WIDTH-1:0]       in_vstart;
    logic [CNT_WIDTH-1:0]       in_vl;
    logic                       out_valid;
    logic                       out_ready;
    logic [RESP_DATA_WIDTH-1:0] out_vec;
    logic [REQ_DATA_WIDTH-1:0]  out_count;
    logic                       out_last;

    // master: CSR front end plus mask consumer; slave: the generator itself
    modport master (
        output in_valid, in_vstart, in_vl, out_ready,
        input  in_ready, out_valid, out_vec, out_count, out_last
    );

    modport slave (
        input  in_valid, in_vstart, in_vl, out_ready,
        output in_ready, out_valid, out_vec, out_count, out_last
    );
endinterface

// File: rtl/vmask_gen.sv
// rtl/vmask_gen.sv - streams [vstart, vl) element masks as W-bit words with running set-bit count
module vmask_gen #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int CNT_WIDTH       = 16
) (
    input  logic        clk,
    input  logic        rst,
    vmask_gen_if.slave  bus
);
    localparam int W  = RESP_DATA_WIDTH;
    localparam int XW = CNT_WIDTH + 2;

    typedef logic [XW-1:0]        ext_t;
    typedef logic [CNT_WIDTH:0]   base_t;
    typedef enum logic {IDLE, EMIT} state_t;

    localparam ext_t  W_EXT  = ext_t'(W);
    localparam base_t W_BASE = base_t'(W);

    state_t                     state;
    logic [CNT_WIDTH-1:0]       vstart_q;
    logic [CNT_WIDTH-1:0]       vl_q;
    base_t                      base_q;
    logic [REQ_DATA_WIDTH-1:0]  count_q;

    logic                       in_ready_q;
    logic                       out_valid_q;
    logic [W-1:0]               out_vec_q;
    logic [REQ_DATA_WIDTH-1:0]  out_count_q;
    logic                       out_last_q;

    logic                       req_empty;
    logic [W-1:0]               first_word;
    logic                       first_last;
    base_t                      next_base;
    logic [REQ_DATA_WIDTH-1:0]  next_count;
    logic [W-1:0]               next_word;
    logic                       next_last;

    // Extra headroom bit keeps base+i from wrapping near the top of the element range.
    function automatic logic [W-1:0] mask_word(input base_t b,
                                               input logic [CNT_WIDTH-1:0] vs,
                                               input logic [CNT_WIDTH-1:0] vl);
        logic [W-1:0] m;
        ext_t         idx;
        m = '0;
        for (int i = 0; i < W; i++) begin
            idx  = ext_t'(b) + ext_t'(i);
            m[i] = (idx >= ext_t'(vs)) && (idx < ext_t'(vl));
        end
        return m;
    endfunction

    function automatic logic [REQ_DATA_WIDTH-1:0] popcount(input logic [W-1:0] v);
        logic [REQ_DATA_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            p = p + REQ_DATA_WIDTH'(v[i]);
        end
        return p;
    endfunction

    always_comb begin
        req_empty  = (bus.in_vl == '0) || (bus.in_vstart >= bus.in_vl);
        first_word = req_empty ? '0 : mask_word('0, bus.in_vstart, bus.in_vl);
        // An empty range still yields exactly one terminating word.
        first_last = req_empty || (W_EXT >= ext_t'(bus.in_vl));
        next_base  = base_q + W_BASE;
        next_count = count_q + popcount(out_vec_q);
        next_word  = mask_word(next_base, vstart_q, vl_q);
        next_last  = (ext_t'(next_base) + W_EXT) >= ext_t'(vl_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            vstart_q    <= '0;
            vl_q        <= '0;
            base_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vstart_q    <= bus.in_vstart;
                        vl_q        <= bus.in_vl;
                        base_q      <= '0;
                        count_q     <= '0;
                        out_vec_q   <= first_word;
                        out_count_q <= '0;
                        out_last_q  <= first_last;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            base_q      <= next_base;
                            count_q     <= next_count;
                            out_vec_q   <= next_word;
                            out_count_q <= next_count;
                            out_last_q  <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_count = out_count_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_vmask_gen.sv
// tb/tb_vmask_gen.sv - randomized self-checking bench for vmask_gen against an element-level model
module tb_vmask_gen;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vmask_gen_if #(.REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .CNT_WIDTH(16)) vif ();

    vmask_gen #(.REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    // Reference: word k bit i is element k*64+i, set iff it lies in [vs, vl).
    function automatic logic [63:0] ref_word(input int vs, input int vl, input int k);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if ((k * 64 + i) >= vs && (k * 64 + i) < vl) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic int ref_words(input int vs, input int vl);
        if (vl == 0 || vs >= vl) return 1;
        return (vl + 63) / 64;
    endfunction

    task automatic run_req(input int vs, input int vl, input bit rnd_ready,
                           input int stall_word, input int stall_cycles);
        int          n;
        int          guard;
        int          stalls;
        longint      ecount;
        logic [63:0] ew;
        logic        el;
        logic        r;
        guard = 0;
        while (vif.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (vif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready vs=%0d vl=%0d in_ready=%b want 1", vs, vl, vif.in_ready);
        end
        vif.in_valid  = 1'b1;
        vif.in_vstart = 16'(vs);
        vif.in_vl     = 16'(vl);
        vif.out_ready = 1'b0;
        @(posedge clk); #1;
        vif.in_valid  = 1'b0;
        vif.in_vstart = 16'($urandom);
        vif.in_vl     = 16'($urandom);
        total++;
        if (vif.out_valid !== 1'b1 || vif.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL latency vs=%0d vl=%0d out_valid=%b in_ready=%b want 1/0",
                     vs, vl, vif.out_valid, vif.in_ready);
        end
        n = ref_words(vs, vl);
        ecount = 0;
        for (int k = 0; k < n; k++) begin
            ew = ref_word(vs, vl, k);
            el = (k == n - 1);
            stalls = 0;
            do begin
                if (k == stall_word && stalls < stall_cycles) r = 1'b0;
                else if (rnd_ready && stalls < 16)            r = ($urandom_range(0, 3) != 0);
                else                                          r = 1'b1;
                vif.out_ready = r;
                total++;
                if (vif.out_valid !== 1'b1 || vif.out_vec !== ew ||
                    vif.out_count !== 64'(ecount) || vif.out_last !== el) begin
                    bad++;
                    $display("FAIL word vs=%0d vl=%0d k=%0d got v=%b vec=%h cnt=%0d last=%b want v=1 vec=%h cnt=%0d last=%b",
                             vs, vl, k, vif.out_valid, vif.out_vec, vif.out_count, vif.out_last,
                             ew, ecount, el);
                end
                @(posedge clk); #1;
                if (!r) stalls++;
            end while (!r);
            ecount += longint'($countones(ew));
        end
        vif.out_ready = 1'b0;
        total++;
        if (vif.out_valid !== 1'b0 || vif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL done vs=%0d vl=%0d out_valid=%b in_ready=%b want 0/1",
                     vs, vl, vif.out_valid, vif.in_ready);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (vif.in_ready !== 1'b1 || vif.out_valid !== 1'b0 || vif.out_vec !== 64'h0 ||
            vif.out_count !== 64'h0 || vif.out_last !== 1'b0) begin
            bad++;
            $display("FAIL %s in_ready=%b out_valid=%b vec=%h cnt=%0d last=%b want 1/0/0/0/0",
                     name, vif.in_ready, vif.out_valid, vif.out_vec, vif.out_count, vif.out_last);
        end
    endtask

    task automatic test_reset();
        vif.in_valid  = 1'b0;
        vif.in_vstart = '0;
        vif.in_vl     = '0;
        vif.out_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_idle_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check_idle_outputs("reset_release");
    endtask

    task automatic test_directed();
        run_req(0, 10, 1'b0, -1, 0);
        run_req(3, 130, 1'b0, -1, 0);
        run_req(70, 100, 1'b0, -1, 0);
        run_req(0, 0, 1'b0, -1, 0);
        run_req(50, 20, 1'b0, -1, 0);
    endtask

    task automatic test_boundaries();
        run_req(0, 64, 1'b0, -1, 0);
        run_req(0, 65, 1'b0, -1, 0);
        run_req(63, 64, 1'b0, -1, 0);
        run_req(64, 64, 1'b0, -1, 0);
        run_req(200, 256, 1'b0, -1, 0);
        run_req(0, 65535, 1'b0, -1, 0);
        run_req(65470, 65535, 1'b0, -1, 0);
    endtask

    task automatic test_backpressure();
        run_req(0, 200, 1'b0, 1, 3);
        run_req(10, 300, 1'b0, 0, 5);
    endtask

    task automatic test_back_to_back();
        run_req(5, 64, 1'b0, -1, 0);
        run_req(1, 129, 1'b0, -1, 0);
        run_req(40, 30, 1'b0, -1, 0);
    endtask

    task automatic test_random();
        int vs;
        int vl;
        for (int it = 0; it < 40; it++) begin
            vl = $urandom_range(0, 400);
            if ($urandom_range(0, 4) == 0) vs = $urandom_range(0, 450);
            else                           vs = $urandom_range(0, vl);
            run_req(vs, vl, 1'b1, -1, 0);
        end
    endtask

    task automatic test_reset_mid();
        vif.in_valid  = 1'b1;
        vif.in_vstart = 16'd0;
        vif.in_vl     = 16'd200;
        vif.out_ready = 1'b1;
        @(posedge clk); #1;
        vif.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        total++;
        if (vif.out_valid !== 1'b1 || vif.out_vec !== 64'hFFFF_FFFF_FFFF_FFFF ||
            vif.out_count !== 64'd128) begin
            bad++;
            $display("FAIL mid_word2 got v=%b vec=%h cnt=%0d want v=1 vec=ffffffffffffffff cnt=128",
                     vif.out_valid, vif.out_vec, vif.out_count);
        end
        #2 rst = 1'b0;
        #1 check_idle_outputs("reset_mid");
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check_idle_outputs("after_reset_mid");
            @(posedge clk); #1;
        end
        vif.out_ready = 1'b0;
        run_req(3, 130, 1'b0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vmask_gen.md
# vmask_gen

Streaming mask-word generator for the vector ALU: converts an element range (vstart, vl) into consecutive RESP_DATA_WIDTH-bit mask words, bit set iff its element index lies in [vstart, vl). Each word is tagged with the running count of set bits emitted earlier in the same request. The mask/count pair feeds directly into the mask-popcount accumulator (in_m0 / in_count). It sits between the vector-length/CSR front end and the mask datapath.

## Interface

- REQ_DATA_WIDTH, 64, width of out_count (matches accumulator count input)
- RESP_DATA_WIDTH, 64, mask word width W (power of two)
- CNT_WIDTH, 16, width of vstart/vl operands

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted at 0)
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_vstart  input  CNT_WIDTH  first active element
- in_vl  input  CNT_WIDTH  vector length (exclusive upper bound)
- out_valid  output  1  mask word valid
- out_ready  input  1  consumer accepts word when out_valid & out_ready
- out_vec  output  RESP_DATA_WIDTH  mask word; bit i of word k = element k*W+i
- out_count  output  REQ_DATA_WIDTH  set bits in all earlier words of this request
- out_last  output  1  final word of request

## Operation

- States: IDLE, EMIT. in_ready = 1 only in IDLE (registered, not combinational on out_ready).
- IDLE, request accepted: latch vstart, vl; word base register b = 0 (CNT_WIDTH+1 bits); running count = 0; go to EMIT with first word loaded.
- Word k: bit i = 1 iff vstart <= b+i < vl, compare in CNT_WIDTH+1 bits (no wrap). Words emitted: N = ceil(vl/W).
- Empty request (vl == 0 or vstart >= vl): exactly one all-zero word, out_count = 0, out_last = 1. Consumer always receives a terminating word.
- Leading all-zero words (vstart >= W) are emitted, not skipped.
- out_last = 1 iff b + W >= vl (or empty request).
- On output handshake: count += popcount(out_vec); b += W; load next word. If out_last was set, go to IDLE instead, out_valid = 0.
- out_count saturates at neither bound; width REQ_DATA_WIDTH always exceeds CNT_WIDTH, no overflow by construction.
- Request inputs ignored outside IDLE; no input is sampled while in EMIT.

## Timing

- Reset (rst = 0, asynchronous): state IDLE, in_ready = 1, out_valid = 0, out_vec = 0, out_count = 0, out_last = 0; internal b, count, vstart, vl = 0. Deassertion is synchronised externally; first accept possible on first edge after release.
- Reset mid-EMIT: request abandoned immediately, outputs at reset values; no remaining words emitted after release.
- Latency: request accepted at edge t -> out_valid = 1 with word 0 from cycle t+1.
- Throughput: one word per cycle while out_ready = 1.
- Backpressure: while out_valid & !out_ready, out_vec, out_count, out_last held stable; out_valid never drops without handshake.
- Last word handshake at edge t -> in_ready = 1 during cycle t+1; next request accepted at earliest at edge t+1, its word 0 valid cycle t+2. One bubble between requests.
- All outputs registered; no combinational path input->output.

## Test plan

- Reset: rst = 0 mid-cycle asynchronously -> in_ready = 1, out_valid/out_vec/out_count/out_last = 0 before next edge.
- vstart = 0, vl = 10 -> one word 0x3FF, out_count 0, out_last 1; in_ready back high the cycle after handshake.
- vstart = 3, vl = 130, out_ready = 1 -> three words on consecutive cycles: 0xFFFF_FFFF_FFFF_FFF8 (count 0), 0xFFFF_FFFF_FFFF_FFFF (count 61), 0x3 (count 125, last).
- vstart = 70, vl = 100 -> word 0x0 (count 0), then 0x0000_000F_FFFF_FFC0 (count 0, last).
- vl = 0 and separately vstart = 50, vl = 20 -> single 0x0 word, count 0, last 1.
- Backpressure: vstart = 0, vl = 200, out_ready low 3 cycles on word 1 -> word 1 (all ones, count 64) held stable; then words 2, 3 follow (0xFF last, count 192). Reset asserted during word 2 -> out_valid 0, no further words after release.
